// File: rtl/sample_loader_pkg.sv
// rtl/sample_loader_pkg.sv - shared states, protocol bytes and table type for the sample loader
package sample_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_START,
    GET_COUNT,
    GET_INPUT,
    GET_EXPECTED,
    GET_VALID,
    GET_CHECKSUM,
    SEND_ACK,
    READY
  } loaderState_t;

  localparam logic [7:0] START_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE   = 8'h06;
  localparam logic [7:0] NAK_BYTE   = 8'h15;

  localparam int DEFAULT_NUM_SAMPLES = 32;

  typedef logic [DEFAULT_NUM_SAMPLES-1:0][7:0] sampleTable_t;

  // A frame must carry at least one sample and no more than the table holds.
  function automatic logic countOk(input logic [7:0] count, input int maxSamples);
    return (count != 8'd0) && (int'(count) <= maxSamples);
  endfunction

endpackage

// File: rtl/serial_sample_loader_if.sv
// rtl/serial_sample_loader_if.sv - UART byte stream and response handshake between host link and loader
interface serial_sample_loader_if;

  logic [7:0] iRxByte;
  logic       iRxValid;
  logic       iTxBusy;
  logic [7:0] oTxByte;
  logic       oTxValid;

  modport master (
    output iRxByte,
    output iRxValid,
    output iTxBusy,
    input  oTxByte,
    input  oTxValid
  );

  modport slave (
    input  iRxByte,
    input  iRxValid,
    input  iTxBusy,
    output oTxByte,
    output oTxValid
  );

endinterface

// File: rtl/serial_sample_loader_byte_timeout_counter.sv
// rtl/serial_sample_loader_byte_timeout_counter.sv - idle-cycle counter raising a one-cycle expiry pulse
module byte_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic iClock,
  input  logic iReset,
  input  logic iClear,
  input  logic iEnable,
  output logic oExpired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idleCount;

  // A byte in the terminal cycle wins, so clear masks the pulse.
  assign oExpired = iEnable && !iClear && (idleCount == TERMINAL);

  always_ff @(posedge iClock) begin
    if (iReset || iClear || !iEnable || oExpired) begin
      idleCount <= '0;
    end else begin
      idleCount <= idleCount + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_sample_loader.sv
// rtl/serial_sample_loader.sv - parses checked sample frames into the table and answers ACK/NAK
module serial_sample_loader
  import sample_loader_pkg::*;
#(
  parameter int NUM_SAMPLES    = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         iClock,
  input  logic                         iReset,
  serial_sample_loader_if.slave        uart,
  input  logic                         iTableConsumed,
  output logic [NUM_SAMPLES-1:0][7:0]  oInputSequences,
  output logic [NUM_SAMPLES-1:0][7:0]  oExpectedOutputs,
  output logic [NUM_SAMPLES-1:0][7:0]  oValidOutputs,
  output logic [7:0]                   oSequencesToProcess,
  output logic                         oTableReady,
  output logic                         oFrameError
);

  localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  loaderState_t     state;
  logic [7:0]       runningSum;
  logic [7:0]       sampleIndex;
  logic [7:0]       nextSum;
  logic [7:0]       nextIndex;
  logic [IDX_W-1:0] writeIndex;
  logic             inFrame;
  logic             timeoutExpired;

  assign inFrame    = (state == GET_COUNT) || (state == GET_INPUT) || (state == GET_EXPECTED)
                   || (state == GET_VALID) || (state == GET_CHECKSUM);
  assign nextSum    = runningSum + uart.iRxByte;
  assign nextIndex  = sampleIndex + 8'd1;
  assign writeIndex = sampleIndex[IDX_W-1:0];

  byte_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) uTimeout (
    .iClock   (iClock),
    .iReset   (iReset),
    .iClear   (uart.iRxValid),
    .iEnable  (inFrame),
    .oExpired (timeoutExpired)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state               <= WAIT_START;
      runningSum          <= '0;
      sampleIndex         <= '0;
      oInputSequences     <= '0;
      oExpectedOutputs    <= '0;
      oValidOutputs       <= '0;
      oSequencesToProcess <= '0;
      uart.oTxByte        <= '0;
      uart.oTxValid       <= 1'b0;
      oTableReady         <= 1'b0;
      oFrameError         <= 1'b0;
    end else begin
      case (state)
        WAIT_START: begin
          if (uart.iRxValid && (uart.iRxByte == START_BYTE)) begin
            runningSum  <= '0;
            oFrameError <= 1'b0;
            state       <= GET_COUNT;
          end
        end

        GET_COUNT: begin
          if (uart.iRxValid) begin
            if (!countOk(uart.iRxByte, NUM_SAMPLES)) begin
              uart.oTxByte  <= NAK_BYTE;
              uart.oTxValid <= 1'b1;
              state         <= SEND_ACK;
            end else begin
              oSequencesToProcess <= uart.iRxByte;
              oValidOutputs       <= '0;
              sampleIndex         <= '0;
              runningSum          <= nextSum;
              state               <= GET_INPUT;
            end
          end else if (timeoutExpired) begin
            uart.oTxByte  <= NAK_BYTE;
            uart.oTxValid <= 1'b1;
            state         <= SEND_ACK;
          end
        end

        GET_INPUT: begin
          if (uart.iRxValid) begin
            oInputSequences[writeIndex] <= uart.iRxByte;
            runningSum                  <= nextSum;
            state                       <= GET_EXPECTED;
          end else if (timeoutExpired) begin
            uart.oTxByte  <= NAK_BYTE;
            uart.oTxValid <= 1'b1;
            state         <= SEND_ACK;
          end
        end

        GET_EXPECTED: begin
          if (uart.iRxValid) begin
            oExpectedOutputs[writeIndex] <= uart.iRxByte;
            runningSum                   <= nextSum;
            state                        <= GET_VALID;
          end else if (timeoutExpired) begin
            uart.oTxByte  <= NAK_BYTE;
            uart.oTxValid <= 1'b1;
            state         <= SEND_ACK;
          end
        end

        GET_VALID: begin
          if (uart.iRxValid) begin
            oValidOutputs[writeIndex] <= uart.iRxByte;
            runningSum                <= nextSum;
            sampleIndex               <= nextIndex;
            state <= (nextIndex == oSequencesToProcess) ? GET_CHECKSUM : GET_INPUT;
          end else if (timeoutExpired) begin
            uart.oTxByte  <= NAK_BYTE;
            uart.oTxValid <= 1'b1;
            state         <= SEND_ACK;
          end
        end

        GET_CHECKSUM: begin
          if (uart.iRxValid) begin
            uart.oTxByte  <= (nextSum == 8'd0) ? ACK_BYTE : NAK_BYTE;
            uart.oTxValid <= 1'b1;
            state         <= SEND_ACK;
          end else if (timeoutExpired) begin
            uart.oTxByte  <= NAK_BYTE;
            uart.oTxValid <= 1'b1;
            state         <= SEND_ACK;
          end
        end

        // Received bytes are dropped here; the response byte is held until the UART takes it.
        SEND_ACK: begin
          if (!uart.iTxBusy) begin
            uart.oTxValid <= 1'b0;
            if (uart.oTxByte == ACK_BYTE) begin
              oTableReady <= 1'b1;
              state       <= READY;
            end else begin
              oFrameError <= 1'b1;
              state       <= WAIT_START;
            end
          end
        end

        READY: begin
          if (iTableConsumed) begin
            oTableReady <= 1'b0;
            state       <= WAIT_START;
          end
        end

        default: state <= WAIT_START;
      endcase
    end
  end

endmodule

// File: doc/serial_sample_loader.md
# serial_sample_loader

Receives test-sample frames byte-by-byte from the UART receiver, checks them, and builds the sample table (input, expected output, valid mask per sample) that the chromosome processing state machine evaluates. It sits directly upstream of that state machine. It returns a one-byte ACK/NAK to the host through the UART transmitter, and it holds the table stable until the downstream stage releases it.

## Interface
Parameters
- NUM_SAMPLES, 32: table depth; maximum samples per frame (1..255).
- TIMEOUT_CYCLES, 1_000_000: maximum idle cycles allowed between bytes inside a frame.

Ports
- iClock  in  1  system clock.
- iReset  in  1  reset; synchronous, active-high.
- iRxByte  in  8  received byte.
- iRxValid  in  1  one-cycle strobe; iRxByte is valid in this cycle.
- iTxBusy  in  1  UART transmitter busy; a byte is accepted only in a cycle where this is 0.
- oTxByte  out  8  response byte: ACK 8'h06 or NAK 8'h15.
- oTxValid  out  1  response pending.
- iTableConsumed  in  1  one-cycle pulse from downstream: table released.
- oInputSequences  out  [NUM_SAMPLES-1:0][7:0]  input vector per sample.
- oExpectedOutputs  out  [NUM_SAMPLES-1:0][7:0]  expected output per sample.
- oValidOutputs  out  [NUM_SAMPLES-1:0][7:0]  per-bit compare mask per sample.
- oSequencesToProcess  out  8  number of samples in the accepted frame.
- oTableReady  out  1  table complete and checked.
- oFrameError  out  1  last frame was rejected; sticky.

## Operation
- Frame format: START 8'hA5, COUNT, then COUNT triplets (INPUT, EXPECTED, VALID), then CHK.
- Checksum rule: the 8-bit sum (mod 256) of COUNT, all triplet bytes and CHK must be 0.
- States:
  - WAIT_START: on a byte equal to A5, clear the running sum, clear oFrameError, go to GET_COUNT. Any other byte is dropped.
  - GET_COUNT: if COUNT is 0 or greater than NUM_SAMPLES, queue NAK and go to SEND_ACK. Otherwise:
    - latch oSequencesToProcess;
    - zero all oValidOutputs entries;
    - set the sample index to 0;
    - go to GET_INPUT.
  - GET_INPUT, GET_EXPECTED, GET_VALID: each byte is written to entry [index] of its table. After GET_VALID, increment the index. If index equals COUNT, go to GET_CHECKSUM; otherwise go back to GET_INPUT.
  - GET_CHECKSUM: if the final sum is 0, queue ACK; otherwise queue NAK. Go to SEND_ACK.
  - SEND_ACK: oTxValid=1. When iTxBusy=0, the byte transfers. After ACK, go to READY. After NAK, set oFrameError=1 and go to WAIT_START.
  - READY: oTableReady=1. On iTableConsumed, go to WAIT_START.
- Inter-byte timeout: applies in GET_COUNT through GET_CHECKSUM. An idle counter resets on every iRxValid. When it reaches TIMEOUT_CYCLES-1, queue NAK and go to SEND_ACK.
- Dropped inputs:
  - iRxValid in SEND_ACK or READY is ignored; the byte is lost.
  - iTableConsumed outside READY is ignored.
- Table registers are written only in the GET_* states. Their contents after a NAK are undefined for downstream use, because oTableReady stays 0.
- An A5 byte arriving mid-frame is treated as data; there is no resynchronisation except by timeout.

## Timing
- Reset (same edge): state=WAIT_START, every table entry=0, oSequencesToProcess=0, oTxByte=0, oTxValid=0, oTableReady=0, oFrameError=0, idle counter=0.
- Reset mid-frame or in READY aborts immediately. No NAK is sent.
- A byte strobed in cycle N is registered into its table, and the state advances, at the edge ending cycle N.
- Response latency: oTxValid rises in the cycle after the CHK byte, the bad COUNT byte, or the timeout cycle.
- TX handshake:
  - oTxValid and oTxByte stay stable while iTxBusy=1.
  - Transfer happens on the edge of the first cycle with oTxValid=1 and iTxBusy=0.
  - oTxValid is 0 in the next cycle.
  - In that same next cycle, oTableReady=1 (ACK) or oFrameError=1 (NAK).
- oTableReady falls in the cycle after iTableConsumed.
- Simultaneous iRxValid and timeout terminal count: the byte wins and the counter resets.

## Structure
- Shared package sample_loader_pkg holds:
  - the state enum;
  - START_BYTE=8'hA5, ACK_BYTE=8'h06, NAK_BYTE=8'h15;
  - the table typedef [NUM_SAMPLES-1:0][7:0].
- Sub-module byte_timeout_counter contains the idle counter.
  - Inputs: clear, enable.
  - Output: one-cycle expired pulse.

## Test plan
- Valid frame: A5,02,01,03,FF,02,00,0F,EA.
  - Response: ACK 06 sent.
  - Table: inputs[0..1]=01,02; expected=03,00; valid=FF,0F; all other valid entries 00.
  - oSequencesToProcess=2; oTableReady=1 in the cycle after the transfer.
- Same frame with CHK=EB.
  - Response: NAK 15; oTableReady=0; oFrameError=1. The next A5 clears oFrameError.
- A5,00.
  - Response: NAK in the cycle after the COUNT byte; state returns to WAIT_START.
- A5,02,01, then silence with TIMEOUT_CYCLES=16.
  - Response: oTxValid=1 with NAK exactly 16 idle cycles after the last byte.
- iTxBusy held at 1 for 5 cycles after a good frame.
  - Response: oTxValid and oTxByte=06 held for 5 cycles; transfer on the 6th; bytes received during SEND_ACK are ignored.
- Reset asserted mid-triplet; then a fresh valid frame.
  - Response: all outputs 0 after reset with no response byte; the fresh frame is then ACKed normally.
- In READY, pulse iTableConsumed.
  - Response: oTableReady=0 in the next cycle; a new frame is accepted.
